// File: rtl/fpu_lzd_norm_sched_if.sv
`timescale 1ns/1ps
// Purpose: requester and result handshake bundle for the shared LZD normaliser.
// Latency: none, wires only.
// Backpressure: valid/ready on both the request side and the result side.
interface fpu_lzd_norm_sched_if;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [63:0] req0_data_i;
  logic [63:0] req1_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        out_id_o;
  logic [6:0]  out_cnt_o;
  logic        out_zero_o;
  logic [63:0] out_norm_o;

  // The scheduler side: takes requests, drives results.
  modport slave (
    input  req_valid_i, req0_data_i, req1_data_i, out_ready_i,
    output req_ready_o, out_valid_o, out_id_o, out_cnt_o, out_zero_o, out_norm_o
  );

  // The requester/consumer side.
  modport master (
    output req_valid_i, req0_data_i, req1_data_i, out_ready_i,
    input  req_ready_o, out_valid_o, out_id_o, out_cnt_o, out_zero_o, out_norm_o
  );
endinterface

// File: rtl/fpu_lzd_norm_sched.sv
`timescale 1ns/1ps
// Purpose: one 32-bit LZD shared by two requesters; 64-bit leading-zero count in two passes.
// Latency: result valid 2 edges after accept (upper half nonzero) or 3 edges (upper half zero).
// Backpressure: result held in DONE until out_ready_i; no request accepted outside IDLE.
// Optional macro FPU_LZD_NORM_SHIFT_EN adds the registered left-normalised mantissa.

module FPU_LZD_32 (
  input  logic [31:0] a,
  output logic [4:0]  pos,
  output logic        val
);
  logic found;

  // Priority scan from the MSB; pos is only meaningful when val is set.
  always_comb begin
    pos   = '0;
    found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!found && a[i]) begin
        pos   = 5'(31 - i);
        found = 1'b1;
      end
    end
  end

  assign val = |a;
endmodule

module fpu_lzd_norm_sched #(
  parameter bit PRIO_INIT = 1'b0
) (
  input logic                     clk,
  input logic                     rst_l,
  fpu_lzd_norm_sched_if.slave     io
);
  typedef enum logic [1:0] {IDLE, HI, LO, DONE} state_t;

  state_t      state;
  logic        last_grant;
  logic        grant;
  logic        accept;
  logic [63:0] op_q;
  logic [6:0]  cnt_q;
  logic        zero_q;
  logic        id_q;
  logic        valid_q;
  logic [31:0] lzd_in;
  logic [4:0]  lzd_pos;
  logic        lzd_val;
  logic        to_done;
  logic [6:0]  cnt_nxt;

  // Round-robin pick: a lone requester wins, a tie goes to whoever did not win last.
  always_comb begin
    grant = io.req_valid_i[1];
    if (&io.req_valid_i) grant = ~last_grant;
  end

  assign accept         = (state == IDLE) && (|io.req_valid_i);
  assign io.req_ready_o = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;

  // Upper half is examined first; the lower half only when the upper is all zeros.
  assign lzd_in = (state == LO) ? op_q[31:0] : op_q[63:32];

  FPU_LZD_32 u_lzd (
    .a   (lzd_in),
    .pos (lzd_pos),
    .val (lzd_val)
  );

  // Count that will be latched on entry to DONE, shared with the optional shifter.
  always_comb begin
    to_done = 1'b0;
    cnt_nxt = cnt_q;
    case (state)
      HI: begin
        if (lzd_val) begin
          to_done = 1'b1;
          cnt_nxt = {2'b00, lzd_pos};
        end
      end
      LO: begin
        to_done = 1'b1;
        cnt_nxt = lzd_val ? (7'd32 + {2'b00, lzd_pos}) : 7'd64;
      end
      default: ;
    endcase
  end

  // Sequencer with registered result outputs.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state      <= IDLE;
      last_grant <= ~PRIO_INIT;
      op_q       <= '0;
      cnt_q      <= '0;
      zero_q     <= 1'b0;
      id_q       <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q       <= grant ? io.req1_data_i : io.req0_data_i;
            id_q       <= grant;
            last_grant <= grant;
            state      <= HI;
          end
        end
        HI: begin
          if (to_done) begin
            cnt_q   <= cnt_nxt;
            valid_q <= 1'b1;
            state   <= DONE;
          end else begin
            state <= LO;
          end
        end
        LO: begin
          cnt_q   <= cnt_nxt;
          zero_q  <= ~lzd_val;
          valid_q <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          if (io.out_ready_i) begin
            valid_q <= 1'b0;
            zero_q  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.out_valid_o = valid_q;
  assign io.out_id_o    = id_q;
  assign io.out_cnt_o   = cnt_q;
  assign io.out_zero_o  = zero_q;

`ifdef FPU_LZD_NORM_SHIFT_EN
  logic [63:0] norm_q;

  // Normalised mantissa captured alongside the count; a count of 64 shifts everything out.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      norm_q <= '0;
    end else if (to_done) begin
      norm_q <= op_q << cnt_nxt;
    end
  end

  assign io.out_norm_o = norm_q;
`else
  assign io.out_norm_o = 64'h0;
`endif
endmodule

// File: tb/tb_fpu_lzd_norm_sched.sv
`timescale 1ns/1ps
// Bench for fpu_lzd_norm_sched: directed cases plus randomized traffic, scoreboard-checked.
module tb_fpu_lzd_norm_sched;
  localparam bit PRIO = 1'b0;

  typedef struct packed {
    logic        id;
    logic [6:0]  cnt;
    logic        zero;
    logic [63:0] norm;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        vld0 = 1'b0, vld1 = 1'b0;
  logic [63:0] dat0 = '0, dat1 = '0;
  logic        ordy = 1'b0;
  logic        ordy_fix = 1'b1;
  logic        rnd_ordy = 1'b0;
  logic        done = 1'b0;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  exp_t        exp_q[$];
  logic        m_last;

  fpu_lzd_norm_sched_if bus();

  assign bus.req_valid_i = {vld1, vld0};
  assign bus.req0_data_i = dat0;
  assign bus.req1_data_i = dat1;
  assign bus.out_ready_i = ordy;

  fpu_lzd_norm_sched #(.PRIO_INIT(PRIO)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .io    (bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    ordy = rnd_ordy ? ($urandom_range(3, 0) != 0) : ordy_fix;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  // Reference: count zeros from the MSB down over the full 64 bits.
  function automatic int lzc64(input logic [63:0] v);
    for (int i = 63; i >= 0; i--) if (v[i]) return 63 - i;
    return 64;
  endfunction

  function automatic logic [63:0] rand_op();
    logic [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(3, 0))
      0: v = v;
      1: v = v >> $urandom_range(63, 0);
      2: v = {32'h0, v[31:0]} >> $urandom_range(31, 0);
      default: v = ($urandom_range(5, 0) == 0) ? 64'h0 : (64'h1 << $urandom_range(63, 0));
    endcase
    return v;
  endfunction

  task automatic set_req(input int r, input logic v, input logic [63:0] d);
    if (r == 0) begin vld0 = v; dat0 = d; end
    else begin vld1 = v; dat1 = d; end
  endtask

  // Issue n requests on one port, holding valid/data until accepted (bounded wait).
  task automatic drive(input int r, input int n, input logic [63:0] fixed, input bit use_fixed,
                       input int max_gap);
    for (int k = 0; k < n; k++) begin
      int t;
      int gap;
      gap = (max_gap == 0) ? 0 : $urandom_range(max_gap, 0);
      repeat (gap) begin @(posedge clk); #1; end
      set_req(r, 1'b1, use_fixed ? fixed : rand_op());
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!bus.req_ready_o[r] && t < 400);
      @(posedge clk);
      #1;
      set_req(r, 1'b0, 64'h0);
    end
  endtask

  // Monitor: models arbitration at accept time, scores results when they appear.
  initial begin
    bit          fresh;
    bit          hs_prev;
    int          wait_cnt;
    exp_t        cur;
    exp_t        e;
    logic        g;
    logic [1:0]  exp_rdy;
    logic [63:0] d;
    logic [72:0] snap;
    fresh = 1'b1;
    hs_prev = 1'b0;
    wait_cnt = 0;
    m_last = ~PRIO;
    snap = '0;
    forever begin
      @(negedge clk);
      if (!rst_l) begin
        n_tests++;
        if (bus.out_valid_o || bus.req_ready_o != 2'b00 || bus.out_id_o || bus.out_cnt_o != 7'd0 ||
            bus.out_zero_o || bus.out_norm_o != 64'h0) begin
          n_fail++;
          $display("FAIL reset_outputs: valid=%0b ready=%b id=%0b cnt=%0d zero=%0b norm=%h, required all zero",
                   bus.out_valid_o, bus.req_ready_o, bus.out_id_o, bus.out_cnt_o, bus.out_zero_o, bus.out_norm_o);
        end
        exp_q.delete();
        fresh = 1'b1;
        hs_prev = 1'b0;
        wait_cnt = 0;
        m_last = ~PRIO;
        continue;
      end
      if (done) begin
        n_tests++;
        if (exp_q.size() != 0) begin
          n_fail++;
          $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
      if (hs_prev) begin
        n_tests++;
        if (|bus.req_valid_i && bus.req_ready_o == 2'b00) begin
          n_fail++;
          $display("FAIL resume_accept: ready=%b with valid=%b one cycle after output handshake, required a grant",
                   bus.req_ready_o, bus.req_valid_i);
        end
      end
      if (bus.out_valid_o) begin
        n_tests++;
        if (bus.req_ready_o != 2'b00) begin
          n_fail++;
          $display("FAIL ready_while_busy: ready=%b, required 00", bus.req_ready_o);
        end
      end
      if (|bus.req_valid_i && bus.req_ready_o == 2'b00) wait_cnt++;
      else wait_cnt = 0;
      if (wait_cnt == 300) begin
        n_tests++;
        n_fail++;
        $display("FAIL starve: valid=%b waited %0d cycles, required an accept", bus.req_valid_i, wait_cnt);
      end
      if (bus.req_ready_o != 2'b00) begin
        g = (&bus.req_valid_i) ? ~m_last : bus.req_valid_i[1];
        exp_rdy = (|bus.req_valid_i) ? (g ? 2'b10 : 2'b01) : 2'b00;
        n_tests++;
        if (bus.req_ready_o != exp_rdy) begin
          n_fail++;
          $display("FAIL grant: ready=%b valid=%b, required %b", bus.req_ready_o, bus.req_valid_i, exp_rdy);
        end
        if (|bus.req_valid_i) begin
          m_last = g;
          d = g ? bus.req1_data_i : bus.req0_data_i;
          e.id = g;
          e.cnt = 7'(lzc64(d));
          e.zero = (d == 64'h0);
`ifdef FPU_LZD_NORM_SHIFT_EN
          e.norm = (d == 64'h0) ? 64'h0 : (d << lzc64(d));
`else
          e.norm = 64'h0;
`endif
          e.lat = (d[63:32] != 32'h0) ? 2 : 3;
          e.acc = cyc;
          exp_q.push_back(e);
        end
      end
      hs_prev = 1'b0;
      if (bus.out_valid_o) begin
        if (fresh) begin
          snap = {bus.out_id_o, bus.out_cnt_o, bus.out_zero_o, bus.out_norm_o};
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_out: id=%0b cnt=%0d with no outstanding request, required none",
                     bus.out_id_o, bus.out_cnt_o);
          end else begin
            cur = exp_q.pop_front();
            if (bus.out_id_o != cur.id || bus.out_cnt_o != cur.cnt || bus.out_zero_o != cur.zero ||
                bus.out_norm_o != cur.norm) begin
              n_fail++;
              $display("FAIL result: id=%0b cnt=%0d zero=%0b norm=%h, required id=%0b cnt=%0d zero=%0b norm=%h",
                       bus.out_id_o, bus.out_cnt_o, bus.out_zero_o, bus.out_norm_o,
                       cur.id, cur.cnt, cur.zero, cur.norm);
            end
            n_tests++;
            if (cyc - cur.acc != cur.lat) begin
              n_fail++;
              $display("FAIL latency: %0d cycles, required %0d (cnt=%0d)", cyc - cur.acc, cur.lat, cur.cnt);
            end
          end
          fresh = 1'b0;
        end else begin
          n_tests++;
          if ({bus.out_id_o, bus.out_cnt_o, bus.out_zero_o, bus.out_norm_o} != snap) begin
            n_fail++;
            $display("FAIL hold_stable: outputs=%h, required %h", {bus.out_id_o, bus.out_cnt_o, bus.out_zero_o,
                     bus.out_norm_o}, snap);
          end
        end
        if (ordy) begin
          fresh = 1'b1;
          hs_prev = 1'b1;
        end
      end
    end
  end

  // Stimulus phases.
  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1 rst_l = 1'b1;
    @(posedge clk); #1;

    // Directed single operations: fast path, slow path, all zeros.
    drive(0, 1, 64'h8000_0000_0000_0000, 1'b1, 0);
    drive(1, 1, 64'h0000_0000_0001_0000, 1'b1, 0);
    drive(0, 1, 64'h0, 1'b1, 0);

    // Both continuously valid: grants alternate.
    fork
      drive(0, 4, 64'h1, 1'b1, 0);
      drive(1, 4, 64'h2, 1'b1, 0);
    join

    // Result held under backpressure while both requesters wait.
    ordy_fix = 1'b0;
    fork
      drive(0, 1, 64'h0000_0F00_0000_0000, 1'b1, 0);
      drive(1, 1, 64'h0000_0000_0000_0003, 1'b1, 0);
    join_none
    repeat (14) @(posedge clk);
    #1 ordy_fix = 1'b1;
    wait fork;

    // Reset while the lower half is being examined.
    drive(0, 1, 64'h0000_0000_0000_00F0, 1'b1, 0);
    @(posedge clk); #1;
    rst_l = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_l = 1'b1;

    // Reset while a result is held, then priority must restart at PRIO_INIT.
    ordy_fix = 1'b0;
    drive(0, 1, 64'h00FF_0000_0000_0000, 1'b1, 0);
    t = 0;
    while (!bus.out_valid_o && t < 10) begin @(posedge clk); #1; t++; end
    rst_l = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_l = 1'b1;
    ordy_fix = 1'b1;
    fork
      drive(0, 2, 64'h0000_0000_8000_0000, 1'b1, 0);
      drive(1, 2, 64'h4000_0000_0000_0000, 1'b1, 0);
    join

    // Randomized traffic with random consumer stalls.
    rnd_ordy = 1'b1;
    fork
      drive(0, 150, 64'h0, 1'b0, 3);
      drive(1, 150, 64'h0, 1'b0, 3);
    join
    rnd_ordy = 1'b0;
    ordy_fix = 1'b1;
    repeat (20) @(posedge clk);
    #1 done = 1'b1;
  end
endmodule
